// File: rtl/mem_request_queue.sv
// rtl/mem_request_queue.sv - in-order request FIFO issuing one request at a time to a bridge user port
// Optional write completion responses: define MEM_REQUEST_QUEUE_WRITE_ACK_EN.
module mem_request_queue #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 128,
  parameter int FIFO_DEPTH_LOG = 3
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [ADDR_WIDTH-1:0]   user_addr,
  output logic                    user_read_enable,
  output logic                    user_write_enable,
  output logic [DATA_WIDTH-1:0]   user_write_data,
  input  logic [DATA_WIDTH-1:0]   user_read_data,
  input  logic                    user_ready,
  output logic [FIFO_DEPTH_LOG:0] queue_count
);
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG;
  localparam logic [FIFO_DEPTH_LOG:0] FULL_COUNT = (FIFO_DEPTH_LOG+1)'(DEPTH);
  localparam logic [FIFO_DEPTH_LOG:0] PTR_ONE    = (FIFO_DEPTH_LOG+1)'(1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  logic [ADDR_WIDTH-1:0] addr_mem  [DEPTH];
  logic [DATA_WIDTH-1:0] wdata_mem [DEPTH];
  logic                  write_mem [DEPTH];

  logic [FIFO_DEPTH_LOG:0] wr_ptr_q, rd_ptr_q, count_q, count_d;
  logic full, empty, push, pop;

  state_t                state_q;
  logic                  tag_q;
  logic [ADDR_WIDTH-1:0] user_addr_q;
  logic [DATA_WIDTH-1:0] user_wdata_q;
  logic                  user_rd_en_q, user_wr_en_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;

  assign full        = (count_q == FULL_COUNT);
  assign empty       = (count_q == '0);
  assign push        = req_valid && !full;
  assign pop         = (state_q == IDLE) && !empty;
  assign req_ready   = !full;
  assign queue_count = count_q;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + PTR_ONE;
    end else if (pop && !push) begin
      count_d = count_q - PTR_ONE;
    end
  end

  // Storage needs no reset: entries are only read once counted in.
  always_ff @(posedge ACLK) begin
    if (push) begin
      addr_mem[wr_ptr_q[FIFO_DEPTH_LOG-1:0]]  <= req_addr;
      wdata_mem[wr_ptr_q[FIFO_DEPTH_LOG-1:0]] <= req_wdata;
      write_mem[wr_ptr_q[FIFO_DEPTH_LOG-1:0]] <= req_write;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q <= count_d;
    end
  end

`ifdef MEM_REQUEST_QUEUE_WRITE_ACK_EN
  logic rsp_write_q;
  assign rsp_write = rsp_write_q;
`else
  assign rsp_write = 1'b0;
`endif

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q      <= IDLE;
      tag_q        <= 1'b0;
      user_addr_q  <= '0;
      user_wdata_q <= '0;
      user_rd_en_q <= 1'b0;
      user_wr_en_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
`ifdef MEM_REQUEST_QUEUE_WRITE_ACK_EN
      rsp_write_q  <= 1'b0;
`endif
    end else begin
      user_rd_en_q <= 1'b0;
      user_wr_en_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!empty) begin
            user_addr_q  <= addr_mem[rd_ptr_q[FIFO_DEPTH_LOG-1:0]];
            user_wdata_q <= write_mem[rd_ptr_q[FIFO_DEPTH_LOG-1:0]] ?
                            wdata_mem[rd_ptr_q[FIFO_DEPTH_LOG-1:0]] : '0;
            user_rd_en_q <= !write_mem[rd_ptr_q[FIFO_DEPTH_LOG-1:0]];
            user_wr_en_q <= write_mem[rd_ptr_q[FIFO_DEPTH_LOG-1:0]];
            tag_q        <= write_mem[rd_ptr_q[FIFO_DEPTH_LOG-1:0]];
            state_q      <= WAIT;
          end
        end
        WAIT: begin
          if (user_ready) begin
`ifdef MEM_REQUEST_QUEUE_WRITE_ACK_EN
            rsp_valid_q <= 1'b1;
            rsp_write_q <= tag_q;
            rsp_rdata_q <= tag_q ? '0 : user_read_data;
            state_q     <= RESP;
`else
            // Unacknowledged writes retire straight back to IDLE.
            if (tag_q) begin
              state_q <= IDLE;
            end else begin
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= user_read_data;
              state_q     <= RESP;
            end
`endif
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign user_addr         = user_addr_q;
  assign user_write_data   = user_wdata_q;
  assign user_read_enable  = user_rd_en_q;
  assign user_write_enable = user_wr_en_q;
  assign rsp_valid         = rsp_valid_q;
  assign rsp_rdata         = rsp_rdata_q;

  a_ready_only_in_wait: assert property (
    @(posedge ACLK) disable iff (ARESET) user_ready |-> (state_q == WAIT));

endmodule

// File: tb/tb_mem_request_queue.sv
// tb/tb_mem_request_queue.sv - directed self-checking bench for mem_request_queue (default build)
`timescale 1ns/1ps
module tb_mem_request_queue;
  localparam int AW = 32;
  localparam int DW = 128;
  localparam int FL = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready, rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] user_addr;
  logic          user_read_enable, user_write_enable;
  logic [DW-1:0] user_write_data, user_read_data;
  logic          user_ready;
  logic [FL:0]   queue_count;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  logic          bridge_stall = 1'b0;
  int            bridge_lat   = 2;
  logic          br_busy      = 1'b0;
  int            br_cnt       = 0;
  logic [AW-1:0] br_addr      = '0;

  logic [AW-1:0] log_addr[$];
  logic          log_we[$];
  logic [DW-1:0] log_wdata[$];
  int            log_cyc[$];
  logic          rsp_log_write[$];
  logic [DW-1:0] rsp_log_rdata[$];
  logic          both_en_seen   = 1'b0;
  logic          rsp_write_seen = 1'b0;

  always #5 clk = ~clk;

  mem_request_queue #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH_LOG(FL)) dut (
    .ACLK(clk), .ARESET(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .user_addr(user_addr), .user_read_enable(user_read_enable),
    .user_write_enable(user_write_enable), .user_write_data(user_write_data),
    .user_read_data(user_read_data), .user_ready(user_ready),
    .queue_count(queue_count)
  );

  function automatic logic [DW-1:0] bridge_data(input logic [AW-1:0] a);
    if (a == 32'h40) return 128'h0123456789ABCDEF0123456789ABCDEF;
    return {a, ~a, a ^ 32'h5A5A5A5A, a | 32'hC0DE0000};
  endfunction

  // Bridge model: logs each enable pulse, completes after bridge_lat cycles unless stalled.
  initial begin
    user_ready = 1'b0;
    user_read_data = '0;
    forever begin
      @(negedge clk);
      cyc++;
      user_ready = 1'b0;
      user_read_data = '0;
      if (rst) begin
        br_busy = 1'b0;
      end else begin
        if (user_read_enable && user_write_enable) both_en_seen = 1'b1;
        if (user_read_enable || user_write_enable) begin
          log_addr.push_back(user_addr);
          log_we.push_back(user_write_enable);
          log_wdata.push_back(user_write_data);
          log_cyc.push_back(cyc);
          br_busy = 1'b1;
          br_cnt  = bridge_lat;
          br_addr = user_addr;
        end else if (br_busy && !bridge_stall) begin
          br_cnt--;
          if (br_cnt == 0) begin
            user_ready = 1'b1;
            user_read_data = bridge_data(br_addr);
            br_busy = 1'b0;
          end
        end
      end
    end
  end

  // Response monitor samples just before the rising edge, after all drives settle.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (!rst) begin
        if (rsp_valid && rsp_write) rsp_write_seen = 1'b1;
        if (rsp_valid && rsp_ready) begin
          rsp_log_write.push_back(rsp_write);
          rsp_log_rdata.push_back(rsp_rdata);
        end
      end
    end
  end

  task automatic clear_logs();
    log_addr.delete(); log_we.delete(); log_wdata.delete(); log_cyc.delete();
    rsp_log_write.delete(); rsp_log_rdata.delete();
  endtask

  task automatic push_req(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int guard = 0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    while (req_ready !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (req_ready !== 1'b1) begin
      nvec++; nerr++;
      $display("FAIL push_timeout addr=%h req_ready=%b required 1", a, req_ready);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    nvec++; if (req_ready !== 1'b1) begin nerr++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    nvec++; if (queue_count !== '0) begin nerr++; $display("FAIL reset_count got=%0d exp=0", queue_count); end
    nvec++; if ({rsp_valid, rsp_write, user_read_enable, user_write_enable} !== 4'b0000) begin
      nerr++; $display("FAIL reset_flags got=%b exp=0000", {rsp_valid, rsp_write, user_read_enable, user_write_enable});
    end
    nvec++; if ({rsp_rdata, user_addr, user_write_data} !== '0) begin
      nerr++; $display("FAIL reset_data got=%h exp=0", {rsp_rdata, user_addr, user_write_data});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    int waited = 0;
    clear_logs(); bridge_lat = 5; bridge_stall = 1'b0; rsp_ready = 1'b1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h40; req_wdata = '1;
    @(negedge clk);
    req_valid = 1'b0;
    nvec++; if (user_read_enable !== 1'b0 || queue_count !== 4'd1) begin
      nerr++; $display("FAIL read_e0 en=%b cnt=%0d exp en=0 cnt=1", user_read_enable, queue_count);
    end
    @(negedge clk);
    nvec++; if ({user_read_enable, user_write_enable} !== 2'b10) begin
      nerr++; $display("FAIL read_issue en=%b exp=10", {user_read_enable, user_write_enable});
    end
    nvec++; if (user_addr !== 32'h40 || user_write_data !== '0 || queue_count !== 4'd0) begin
      nerr++; $display("FAIL read_issue_fields addr=%h wd=%h cnt=%0d exp 40/0/0", user_addr, user_write_data, queue_count);
    end
    while (rsp_valid !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    nvec++; if (waited != 6) begin nerr++; $display("FAIL read_latency got=%0d exp=6", waited); end
    nvec++; if (rsp_rdata !== 128'h0123456789ABCDEF0123456789ABCDEF || rsp_write !== 1'b0) begin
      nerr++; $display("FAIL read_rsp rdata=%h wr=%b exp 0123456789ABCDEF0123456789ABCDEF/0", rsp_rdata, rsp_write);
    end
    repeat (3) @(negedge clk);
    nvec++; if (log_addr.size() != 1 || rsp_log_rdata.size() != 1) begin
      nerr++; $display("FAIL read_counts issued=%0d rsps=%0d exp 1/1", log_addr.size(), rsp_log_rdata.size());
    end
  endtask

  task automatic test_fill();
    int acc = 0;
    logic rdy;
    clear_logs(); bridge_stall = 1'b1; bridge_lat = 2; rsp_ready = 1'b1;
    for (int k = 0; k < 14; k++) begin
      rdy = req_ready;
      req_valid = 1'b1; req_write = 1'b1;
      req_addr = 32'h200 + 32'(16 * acc);
      req_wdata = {4{32'hF0000000 + 32'(acc)}};
      @(negedge clk);
      if (rdy) acc++;
    end
    nvec++; if (acc != 9) begin nerr++; $display("FAIL fill_accepted got=%0d exp=9", acc); end
    nvec++; if (req_ready !== 1'b0 || queue_count !== 4'd8) begin
      nerr++; $display("FAIL fill_full ready=%b cnt=%0d exp 0/8", req_ready, queue_count);
    end
    nvec++; if (log_addr.size() != 1) begin nerr++; $display("FAIL fill_issued got=%0d exp=1", log_addr.size()); end
    req_valid = 1'b0;
    bridge_stall = 1'b0;
    repeat (80) @(negedge clk);
    nvec++; if (queue_count !== 4'd0 || log_addr.size() != 9) begin
      nerr++; $display("FAIL fill_drain cnt=%0d issued=%0d exp 0/9", queue_count, log_addr.size());
    end
    if (log_addr.size() == 9) begin
      for (int i = 0; i < 9; i++) begin
        nvec++;
        if (log_addr[i] !== 32'h200 + 32'(16 * i) || log_we[i] !== 1'b1 ||
            log_wdata[i] !== {4{32'hF0000000 + 32'(i)}}) begin
          nerr++; $display("FAIL fill_order[%0d] addr=%h we=%b wd=%h", i, log_addr[i], log_we[i], log_wdata[i]);
        end
      end
    end
    nvec++; if (rsp_log_rdata.size() != 0) begin nerr++; $display("FAIL fill_no_rsp got=%0d exp=0", rsp_log_rdata.size()); end
  endtask

  task automatic test_ordering();
    logic [DW-1:0] wd;
    clear_logs(); bridge_stall = 1'b0; bridge_lat = 3; rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wd = {4{32'hA0000000 + 32'(i)}};
      push_req(i[0], 32'h100 + 32'(16 * i), wd);
    end
    repeat (60) @(negedge clk);
    nvec++; if (log_addr.size() != 4) begin nerr++; $display("FAIL order_issued got=%0d exp=4", log_addr.size()); end
    if (log_addr.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        wd = i[0] ? {4{32'hA0000000 + 32'(i)}} : '0;
        nvec++;
        if (log_addr[i] !== 32'h100 + 32'(16 * i) || log_we[i] !== i[0] || log_wdata[i] !== wd) begin
          nerr++; $display("FAIL order_req[%0d] addr=%h we=%b wd=%h", i, log_addr[i], log_we[i], log_wdata[i]);
        end
      end
    end
    nvec++; if (rsp_log_rdata.size() != 2) begin nerr++; $display("FAIL order_rsp_count got=%0d exp=2", rsp_log_rdata.size()); end
    if (rsp_log_rdata.size() == 2) begin
      nvec++;
      if (rsp_log_rdata[0] !== bridge_data(32'h100) || rsp_log_rdata[1] !== bridge_data(32'h120) ||
          rsp_log_write[0] !== 1'b0 || rsp_log_write[1] !== 1'b0) begin
        nerr++; $display("FAIL order_rsp got=%h,%h exp=%h,%h", rsp_log_rdata[0], rsp_log_rdata[1],
                         bridge_data(32'h100), bridge_data(32'h120));
      end
    end
  endtask

  task automatic test_backpressure();
    int waited = 0;
    logic stable = 1'b1;
    clear_logs(); bridge_stall = 1'b0; bridge_lat = 2; rsp_ready = 1'b0;
    push_req(1'b0, 32'h300, '0);
    push_req(1'b0, 32'h310, '0);
    while (rsp_valid !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    for (int k = 0; k < 20; k++) begin
      if (rsp_valid !== 1'b1 || rsp_rdata !== bridge_data(32'h300) || rsp_write !== 1'b0 ||
          user_read_enable !== 1'b0 || queue_count !== 4'd1) stable = 1'b0;
      @(negedge clk);
    end
    nvec++; if (stable !== 1'b1) begin
      nerr++; $display("FAIL bp_stable valid=%b rdata=%h cnt=%0d exp 1/%h/1", rsp_valid, rsp_rdata, queue_count, bridge_data(32'h300));
    end
    nvec++; if (log_addr.size() != 1) begin nerr++; $display("FAIL bp_issued got=%0d exp=1", log_addr.size()); end
    rsp_ready = 1'b1;
    @(negedge clk);
    nvec++; if (rsp_valid !== 1'b0 || user_read_enable !== 1'b0) begin
      nerr++; $display("FAIL bp_handshake valid=%b en=%b exp 0/0", rsp_valid, user_read_enable);
    end
    @(negedge clk);
    nvec++; if (user_read_enable !== 1'b1 || user_addr !== 32'h310) begin
      nerr++; $display("FAIL bp_next_issue en=%b addr=%h exp 1/310", user_read_enable, user_addr);
    end
    repeat (10) @(negedge clk);
    nvec++; if (rsp_log_rdata.size() != 2) begin nerr++; $display("FAIL bp_rsp_count got=%0d exp=2", rsp_log_rdata.size()); end
    else begin
      nvec++; if (rsp_log_rdata[0] !== bridge_data(32'h300) || rsp_log_rdata[1] !== bridge_data(32'h310)) begin
        nerr++; $display("FAIL bp_rsp_data got=%h,%h", rsp_log_rdata[0], rsp_log_rdata[1]);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    clear_logs(); bridge_stall = 1'b1; bridge_lat = 2; rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_req(1'b0, 32'h400 + 32'(16 * i), '0);
    nvec++; if (queue_count !== 4'd3 || log_addr.size() != 1) begin
      nerr++; $display("FAIL rst_pre cnt=%0d issued=%0d exp 3/1", queue_count, log_addr.size());
    end
    rst = 1'b1;
    #1;
    nvec++; if (queue_count !== '0 || req_ready !== 1'b1) begin
      nerr++; $display("FAIL rst_async cnt=%0d ready=%b exp 0/1", queue_count, req_ready);
    end
    nvec++; if ({rsp_valid, user_read_enable, user_write_enable} !== 3'b000 ||
                {rsp_rdata, user_addr, user_write_data} !== '0) begin
      nerr++; $display("FAIL rst_outputs flags=%b addr=%h", {rsp_valid, user_read_enable, user_write_enable}, user_addr);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bridge_stall = 1'b0;
    clear_logs();
    repeat (40) @(negedge clk);
    nvec++; if (log_addr.size() != 0 || rsp_log_rdata.size() != 0 || queue_count !== '0) begin
      nerr++; $display("FAIL rst_after issued=%0d rsps=%0d cnt=%0d exp 0/0/0", log_addr.size(), rsp_log_rdata.size(), queue_count);
    end
  endtask

  task automatic test_macro_off();
    clear_logs(); bridge_stall = 1'b0; bridge_lat = 2; rsp_ready = 1'b1;
    push_req(1'b1, 32'h500, {4{32'h55AA55AA}});
    push_req(1'b0, 32'h510, '0);
    repeat (30) @(negedge clk);
    nvec++; if (log_addr.size() != 2) begin nerr++; $display("FAIL woff_issued got=%0d exp=2", log_addr.size()); end
    else begin
      nvec++; if (log_we[0] !== 1'b1 || log_we[1] !== 1'b0 || log_wdata[0] !== {4{32'h55AA55AA}}) begin
        nerr++; $display("FAIL woff_kinds we=%b%b wd=%h", log_we[0], log_we[1], log_wdata[0]);
      end
      nvec++; if (log_cyc[1] - log_cyc[0] != 4) begin
        nerr++; $display("FAIL woff_gap got=%0d exp=4", log_cyc[1] - log_cyc[0]);
      end
    end
    nvec++; if (rsp_log_rdata.size() != 1) begin nerr++; $display("FAIL woff_rsp_count got=%0d exp=1", rsp_log_rdata.size()); end
    else begin
      nvec++; if (rsp_log_write[0] !== 1'b0 || rsp_log_rdata[0] !== bridge_data(32'h510)) begin
        nerr++; $display("FAIL woff_rsp wr=%b rdata=%h exp 0/%h", rsp_log_write[0], rsp_log_rdata[0], bridge_data(32'h510));
      end
    end
    nvec++; if (rsp_write_seen !== 1'b0 || both_en_seen !== 1'b0) begin
      nerr++; $display("FAIL global_flags rsp_write_seen=%b both_en=%b exp 0/0", rsp_write_seen, both_en_seen);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_fill();
    test_ordering();
    test_backpressure();
    test_reset_mid_wait();
    test_macro_off();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout vectors=%0d", nvec);
    $fatal(1, "watchdog");
  end

endmodule
